dpll_acq_controller: RTL and testbench

DPLL_ACQ_CONTROLLER -- requirements
Module: dpll_acq_controller

---
 rtl/dpll_acq_controller.sv | 152 +++++++++++++++
 tb/tb_dpll_acq_controller.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dpll_acq_controller.sv
// Acquisition sequencer for a read-channel DPLL. It walks the loop from a wide-gain pull-in to a narrow-gain track state.
// Every output is a registered Moore decode, so it changes on the same edge as `state`.
module dpll_acq_controller #(
    parameter int SETTLE_BITS = 16,
    parameter int MAX_RETRIES = 3,
    parameter int TO_W        = 20
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            pll_locked,
    input  logic            bit_ready,
    input  logic [TO_W-1:0] acq_timeout,
    output logic [1:0]      gain_sel,
    output logic            nco_reset,
    output logic            data_valid,
    output logic [2:0]      state,
    output logic            acq_fail,
    output logic            fault,
    output logic [7:0]      relock_count
);

    localparam int SW = (SETTLE_BITS < 2) ? 1 : $clog2(SETTLE_BITS + 1);
    localparam int RW = (MAX_RETRIES < 2) ? 1 : $clog2(MAX_RETRIES + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PRESET  = 3'd1,
        ACQUIRE = 3'd2,
        SETTLE  = 3'd3,
        TRACK   = 3'd4,
        FAULT   = 3'd5
    } state_t;

    state_t          st;
    state_t          st_nxt;
    logic [TO_W-1:0] timer;
    logic [TO_W-1:0] timer_nxt;
    logic [SW-1:0]   settle_cnt;
    logic [SW-1:0]   settle_nxt;
    logic [RW-1:0]   retries;
    logic [RW-1:0]   retries_nxt;
    logic [7:0]      relock_nxt;
    logic            fail_nxt;
    logic            timed_out;
    logic            retries_exhausted;
    logic            settle_done;

    // Output field order is {gain_sel, nco_reset, data_valid, fault}.
    function automatic logic [4:0] decode(input state_t s);
        case (s)
            PRESET:  decode = 5'b11_1_0_0;
            ACQUIRE: decode = 5'b11_0_0_0;
            SETTLE:  decode = 5'b10_0_0_0;
            TRACK:   decode = 5'b01_0_1_0;
            FAULT:   decode = 5'b00_0_0_1;
            default: decode = 5'b00_0_0_0;
        endcase
    endfunction

    assign timed_out         = (acq_timeout != '0) && (timer == acq_timeout - TO_W'(1));
    assign retries_exhausted = (int'(retries) + 1) >= MAX_RETRIES;
    assign settle_done       = bit_ready && (int'(settle_cnt) == SETTLE_BITS - 1);

    always_comb begin
        st_nxt      = st;
        timer_nxt   = timer;
        settle_nxt  = settle_cnt;
        retries_nxt = retries;
        relock_nxt  = relock_count;
        fail_nxt    = 1'b0;
        if (!enable) begin
            st_nxt      = IDLE;
            timer_nxt   = '0;
            settle_nxt  = '0;
            retries_nxt = '0;
        end else begin
            case (st)
                IDLE: begin
                    st_nxt      = PRESET;
                    retries_nxt = '0;
                end
                PRESET: begin
                    st_nxt    = ACQUIRE;
                    timer_nxt = '0;
                end
                ACQUIRE: begin
                    timer_nxt = timer + TO_W'(1);
                    // Lock wins over a timeout that lands on the same cycle.
                    if (pll_locked) begin
                        st_nxt     = SETTLE;
                        settle_nxt = '0;
                    end else if (timed_out) begin
                        fail_nxt    = 1'b1;
                        retries_nxt = retries + RW'(1);
                        st_nxt      = retries_exhausted ? FAULT : PRESET;
                    end
                end
                SETTLE: begin
                    if (!pll_locked) begin
                        st_nxt    = ACQUIRE;
                        timer_nxt = '0;
                    end else if (bit_ready) begin
                        if (settle_done) begin
                            st_nxt = TRACK;
                        end else begin
                            settle_nxt = settle_cnt + SW'(1);
                        end
                    end
                end
                TRACK: begin
                    if (!pll_locked) begin
                        st_nxt    = ACQUIRE;
                        timer_nxt = '0;
                        if (relock_count != 8'hFF) begin
                            relock_nxt = relock_count + 8'd1;
                        end
                    end
                end
                FAULT: begin
                    st_nxt = FAULT;
                end
                default: begin
                    st_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st                                       <= IDLE;
            timer                                    <= '0;
            settle_cnt                               <= '0;
            retries                                  <= '0;
            relock_count                             <= '0;
            acq_fail                                 <= 1'b0;
            {gain_sel, nco_reset, data_valid, fault} <= '0;
        end else begin
            st                                       <= st_nxt;
            timer                                    <= timer_nxt;
            settle_cnt                               <= settle_nxt;
            retries                                  <= retries_nxt;
            relock_count                             <= relock_nxt;
            acq_fail                                 <= fail_nxt;
            {gain_sel, nco_reset, data_valid, fault} <= decode(st_nxt);
        end
    end

    assign state = st;

endmodule

// File: tb/tb_dpll_acq_controller.sv
// Scoreboarded bench for dpll_acq_controller: expected state/output snapshots are queued with each stimulus
// and popped whenever the DUT changes state; timing and counters are checked directly.
`timescale 1ns/1ps
module tb_dpll_acq_controller;
    localparam int TO_W = 20;

    // Snapshot layout {state, gain_sel, nco_reset, data_valid, fault}, taken from the spec's output table.
    localparam logic [7:0] E_IDLE    = {3'd0, 2'b00, 1'b0, 1'b0, 1'b0};
    localparam logic [7:0] E_PRESET  = {3'd1, 2'b11, 1'b1, 1'b0, 1'b0};
    localparam logic [7:0] E_ACQUIRE = {3'd2, 2'b11, 1'b0, 1'b0, 1'b0};
    localparam logic [7:0] E_SETTLE  = {3'd3, 2'b10, 1'b0, 1'b0, 1'b0};
    localparam logic [7:0] E_TRACK   = {3'd4, 2'b01, 1'b0, 1'b1, 1'b0};
    localparam logic [7:0] E_FAULT   = {3'd5, 2'b00, 1'b0, 1'b0, 1'b1};

    logic            clk = 1'b0;
    logic            reset;
    logic            enable;
    logic            pll_locked;
    logic            bit_ready;
    logic [TO_W-1:0] acq_timeout;
    logic [1:0]      gain_sel;
    logic            nco_reset;
    logic            data_valid;
    logic [2:0]      state;
    logic            acq_fail;
    logic            fault;
    logic [7:0]      relock_count;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    bit         mon_en = 1'b0;
    logic [2:0] prev_state;

    dpll_acq_controller #(.SETTLE_BITS(16), .MAX_RETRIES(3), .TO_W(TO_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .pll_locked   (pll_locked),
        .bit_ready    (bit_ready),
        .acq_timeout  (acq_timeout),
        .gain_sel     (gain_sel),
        .nco_reset    (nco_reset),
        .data_valid   (data_valid),
        .state        (state),
        .acq_fail     (acq_fail),
        .fault        (fault),
        .relock_count (relock_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Each state change consumes one queued snapshot.
    always @(negedge clk) begin
        if (mon_en && state !== prev_state) begin
            if (exp_q.size() == 0)
                check_val("sb_unexpected_transition", exp_q.size(), 1);
            else
                check_val("sb_transition", {state, gain_sel, nco_reset, data_valid, fault}, exp_q.pop_front());
        end
        prev_state = state;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_bits(input int n);
        for (int i = 0; i < n; i++) begin
            bit_ready = 1'b1;
            tick();
            bit_ready = 1'b0;
            tick();
        end
    endtask

    task automatic drain(input string tag);
        tick();
        check_val(tag, exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        checks++;
        errors++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int fails[$];
        int fail_st[$];
        int cnt;
        int n;

        reset = 1'b1; enable = 1'b0; pll_locked = 1'b0; bit_ready = 1'b0; acq_timeout = '0;
        tick(3);
        check_val("rst_state", state, 0);
        check_val("rst_outs", {gain_sel, nco_reset, data_valid, acq_fail, fault}, 0);
        check_val("rst_relock", relock_count, 0);
        reset = 1'b0;
        prev_state = state;
        mon_en = 1'b1;

        // Normal acquisition: PRESET, ACQUIRE, SETTLE, TRACK.
        exp_q.push_back(E_PRESET); exp_q.push_back(E_ACQUIRE);
        exp_q.push_back(E_SETTLE); exp_q.push_back(E_TRACK);
        enable = 1'b1;
        tick();
        check_val("s1_preset_nco", nco_reset, 1);
        tick(10);
        pll_locked = 1'b1;
        tick();
        check_val("s1_settle", state, 3);
        pulse_bits(15);
        check_val("s1_15_bits_still_settle", state, 3);
        pulse_bits(1);
        check_val("s1_track", state, 4);
        check_val("s1_data_valid", data_valid, 1);
        drain("s1_drain");

        // 300 losses of lock in TRACK; relock_count saturates at 255.
        for (int i = 1; i <= 300; i++) begin
            exp_q.push_back(E_ACQUIRE); exp_q.push_back(E_SETTLE); exp_q.push_back(E_TRACK);
            pll_locked = 1'b0;
            tick();
            check_val("s3_relock", relock_count, (i > 255) ? 255 : i);
            pll_locked = 1'b1;
            tick();
            pulse_bits(16);
        end
        drain("s3_drain");

        // Enable drop in SETTLE, then lock loss racing the last settle bit.
        exp_q.push_back(E_ACQUIRE); exp_q.push_back(E_SETTLE); exp_q.push_back(E_IDLE);
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        tick();
        enable = 1'b0;
        tick();
        check_val("s5_idle_gain", gain_sel, 0);
        check_val("s5_relock_kept", relock_count, 255);
        drain("s5_idle_drain");
        exp_q.push_back(E_PRESET); exp_q.push_back(E_ACQUIRE); exp_q.push_back(E_SETTLE);
        enable = 1'b1;
        tick(3);
        pulse_bits(15);
        exp_q.push_back(E_ACQUIRE);
        bit_ready = 1'b1; pll_locked = 1'b0;
        tick();
        bit_ready = 1'b0;
        check_val("s5_lock_loss_priority", state, 2);
        exp_q.push_back(E_SETTLE);
        pll_locked = 1'b1;
        tick();
        pulse_bits(15);
        check_val("s5_settle_restart", state, 3);
        exp_q.push_back(E_TRACK);
        pulse_bits(1);
        check_val("s5_track", state, 4);
        drain("s5_drain");

        // Reset in TRACK wins over enable and lock.
        exp_q.push_back(E_IDLE);
        reset = 1'b1;
        tick();
        check_val("s4_state", state, 0);
        check_val("s4_outs", {gain_sel, nco_reset, data_valid, acq_fail, fault}, 0);
        check_val("s4_relock", relock_count, 0);
        reset = 1'b0; enable = 1'b0; pll_locked = 1'b0;
        drain("s4_drain");

        // Timeout 50, never locking: acq_fail every 51 cycles, FAULT after the third.
        acq_timeout = 50;
        exp_q.push_back(E_PRESET); exp_q.push_back(E_ACQUIRE);
        exp_q.push_back(E_PRESET); exp_q.push_back(E_ACQUIRE);
        exp_q.push_back(E_PRESET); exp_q.push_back(E_ACQUIRE);
        exp_q.push_back(E_FAULT);
        enable = 1'b1;
        tick();
        for (int k = 1; k <= 200; k++) begin
            tick();
            if (acq_fail) begin
                fails.push_back(k);
                fail_st.push_back(state);
            end
        end
        check_val("s2_fail_count", fails.size(), 3);
        if (fails.size() == 3) begin
            check_val("s2_fail0_cycle", fails[0], 51);
            check_val("s2_fail1_cycle", fails[1], 102);
            check_val("s2_fail2_cycle", fails[2], 153);
            check_val("s2_fail0_state", fail_st[0], 1);
            check_val("s2_fail2_state", fail_st[2], 5);
        end
        check_val("s2_fault_hold", {state, fault}, {3'd5, 1'b1});
        exp_q.push_back(E_IDLE);
        enable = 1'b0;
        tick();
        check_val("s2_fault_cleared", fault, 0);
        drain("s2_drain");

        // Lock on the timer's last cycle: SETTLE, no acq_fail, retry count untouched.
        exp_q.push_back(E_PRESET); exp_q.push_back(E_ACQUIRE);
        exp_q.push_back(E_PRESET); exp_q.push_back(E_ACQUIRE);
        exp_q.push_back(E_SETTLE); exp_q.push_back(E_ACQUIRE);
        exp_q.push_back(E_PRESET); exp_q.push_back(E_ACQUIRE);
        exp_q.push_back(E_FAULT);
        enable = 1'b1;
        tick();
        tick(51);
        check_val("s6_first_fail", acq_fail, 1);
        tick(50);
        pll_locked = 1'b1;
        tick();
        check_val("s6_settle", state, 3);
        check_val("s6_no_fail", acq_fail, 0);
        pll_locked = 1'b0;
        tick();
        check_val("s6_reacquire", state, 2);
        cnt = 0;
        n = 0;
        while (state !== 3'd5 && n < 150) begin
            tick();
            n++;
            if (acq_fail) cnt++;
        end
        check_val("s6_fails_to_fault", cnt, 2);
        check_val("s6_cycles_to_fault", n, 101);
        exp_q.push_back(E_IDLE);
        enable = 1'b0;
        tick();
        drain("s6_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
